bitset_reg: RTL and testbench

Parametrised bit-set register: a WIDTH-bit state register that commands modify in place (write one bit, toggle one bit, load the whole word) through a valid/ready interface. A multi-cycle scan searches the register for the next bit at a given value, starting from an index and wrapping around. It is the sequential successor to the team's 4-bit combinational bitset and serves as the flag/allocation register for control logic that needs per-bit updates and a find-next-bit search.

---
 rtl/bitset_reg.sv | 174 +++++++++++++++++
 tb/tb_bitset_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitset_reg.sv
// bitset_reg: WIDTH-bit flag/allocation register with per-bit commands
// and a multi-cycle wrapping find-next-bit scan.
//
// Optional feature macro: BITSET_REG_SCAN_EN
//   defined   -> SCAN command searches q for the next bit equal to a value
//   undefined -> no scan hardware; op 11 is a no-op, cmd_ready tied high,
//                res_* outputs tied low
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted
//   cmd_op     in   00 WRITE_BIT, 01 TOGGLE_BIT, 10 LOAD, 11 SCAN
//   cmd_index  in   bit index (WRITE/TOGGLE) or scan start index (SCAN)
//   cmd_value  in   bit value to write (WRITE) or to search for (SCAN)
//   cmd_data   in   word to load (LOAD)
//   q          out  register contents
//   res_valid  out  one-cycle pulse on scan completion
//   res_found  out  scan found a matching bit
//   res_index  out  scan result index (start index on a miss)
//
// WIDTH must be a power of two so the scan pointer wraps naturally.
//
// FSM states (only built with BITSET_REG_SCAN_EN):
//   state   | meaning
//   ST_IDLE | accepting commands, cmd_ready = 1
//   ST_SCAN | testing q[ptr] once per cycle, cmd_ready = 0

module bitset_reg #(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_index,
    input  logic             cmd_value,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] q,
    output logic             res_valid,
    output logic             res_found,
    output logic [IDX_W-1:0] res_index
);

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_TOGGLE = 2'b01;
    localparam logic [1:0] OP_LOAD   = 2'b10;
    localparam logic [1:0] OP_SCAN   = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic             w_ready;
    logic             w_accept;

    assign w_accept = cmd_valid && w_ready;

    // Register updates only happen on accept, and accept is impossible
    // while a scan is running, so q is frozen for the whole scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (w_accept) begin
            unique case (cmd_op)
                OP_WRITE:  r_q[cmd_index] <= cmd_value;
                OP_TOGGLE: r_q[cmd_index] <= ~r_q[cmd_index];
                OP_LOAD:   r_q <= cmd_data;
                OP_SCAN:   r_q <= r_q;
            endcase
        end
    end

    assign q         = r_q;
    assign cmd_ready = w_ready;

`ifdef BITSET_REG_SCAN_EN

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_start;
    logic [IDX_W-1:0] r_count;
    logic             r_value;
    logic             r_res_valid;
    logic             r_res_found;
    logic [IDX_W-1:0] r_res_index;
    logic             w_hit;
    logic             w_last;

    assign w_hit  = (r_q[r_ptr] == r_value);
    assign w_last = (r_count == IDX_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (cmd_valid && cmd_op == OP_SCAN) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_hit || w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_start     <= '0;
            r_count     <= '0;
            r_value     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_found <= 1'b0;
            r_res_index <= '0;
        end else begin
            r_res_valid <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_accept && cmd_op == OP_SCAN) begin
                    r_ptr   <= cmd_index;
                    r_start <= cmd_index;
                    r_value <= cmd_value;
                    r_count <= '0;
                end
            end else if (w_hit) begin
                r_res_valid <= 1'b1;
                r_res_found <= 1'b1;
                r_res_index <= r_ptr;
            end else if (w_last) begin
                // Miss reports the start index so the caller can tell
                // where the unsuccessful search began.
                r_res_valid <= 1'b1;
                r_res_found <= 1'b0;
                r_res_index <= r_start;
            end else begin
                // Power-of-two width: overflow is the wrap to bit 0.
                r_ptr   <= r_ptr + IDX_W'(1);
                r_count <= r_count + IDX_W'(1);
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_found = r_res_found;
    assign res_index = r_res_index;

`else

    assign w_ready   = 1'b1;
    assign res_valid = 1'b0;
    assign res_found = 1'b0;
    assign res_index = '0;

`endif

endmodule

// File: tb/tb_bitset_reg.sv
module tb_bitset_reg;

    localparam int W  = 8;
    localparam int IW = 3;

`ifdef BITSET_REG_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [IW-1:0] cmd_index;
    logic          cmd_value;
    logic [W-1:0]  cmd_data;
    logic [W-1:0]  q;
    logic          res_valid;
    logic          res_found;
    logic [IW-1:0] res_index;

    bitset_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_index (cmd_index),
        .cmd_value (cmd_value),
        .cmd_data  (cmd_data),
        .q         (q),
        .res_valid (res_valid),
        .res_found (res_found),
        .res_index (res_index)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the register as a plain word, a scan as a pending
    // result plus the number of cycles left until it is reported.
    logic [W-1:0]  m_q;
    int            m_busy;
    logic          m_rv;
    logic          m_found;
    logic [IW-1:0] m_idx;
    logic          m_pfound;
    logic [IW-1:0] m_pidx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = '0; m_busy = 0; m_rv = 1'b0; m_found = 1'b0; m_idx = '0;
        m_pfound = 1'b0; m_pidx = '0;
    endtask

    // Offset k of the first bit equal to v going upward from s with wrap;
    // the result appears k+1 cycles after accept, or W cycles on a miss.
    task automatic search(input logic [W-1:0] qv, input int s, input logic v,
                          output logic f, output logic [IW-1:0] ix, output int lat);
        f = 1'b0; ix = IW'(s); lat = W;
        for (int k = 0; k < W; k++) begin
            if (qv[(s + k) % W] == v) begin
                f = 1'b1; ix = IW'((s + k) % W); lat = k + 1;
                break;
            end
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            m_rv = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_rv = 1'b1; m_found = m_pfound; m_idx = m_pidx;
                end
            end else if (cmd_valid) begin
                case (cmd_op)
                    2'b00: m_q[cmd_index] = cmd_value;
                    2'b01: m_q[cmd_index] = ~m_q[cmd_index];
                    2'b10: m_q = cmd_data;
                    default: if (SCAN_EN) search(m_q, int'(cmd_index), cmd_value, m_pfound, m_pidx, m_busy);
                endcase
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".q"},         q,         m_q);
        check({tag, ".cmd_ready"}, cmd_ready, (m_busy == 0));
        check({tag, ".res_valid"}, res_valid, m_rv);
        check({tag, ".res_found"}, res_found, m_found);
        check({tag, ".res_index"}, res_index, m_idx);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input int idx,
                         input logic val, input logic [W-1:0] d);
        cmd_valid = v; cmd_op = op; cmd_index = IW'(idx); cmd_value = val; cmd_data = d;
    endtask

    task automatic scan_seq(input logic [W-1:0] qv, input int s, input logic v,
                            input bit with_load, input logic exp_found,
                            input int exp_idx, input int exp_lat);
        drive(1'b1, 2'b10, 0, 1'b0, qv);
        step("scan_preload");
        drive(1'b1, 2'b11, s, v, '0);
        step("scan_accept");
`ifdef BITSET_REG_SCAN_EN
        if (with_load) drive(1'b1, 2'b10, 0, 1'b0, 8'h00);
        else           cmd_valid = 1'b0;
        for (int i = 0; i < exp_lat; i++) begin
            check("scan_busy_ready", cmd_ready, 1'b0);
            check("scan_busy_q", q, qv);
            step("scan_busy");
        end
        check("scan_res_valid", res_valid, 1'b1);
        check("scan_res_found", res_found, exp_found);
        check("scan_res_index", res_index, IW'(exp_idx));
        check("scan_ready_back", cmd_ready, 1'b1);
        check("scan_q_frozen", q, qv);
        if (with_load) begin
            step("scan_late_load");
            check("late_load_q", q, 8'h00);
        end
        cmd_valid = 1'b0;
        step("scan_after");
        check("scan_pulse_once", res_valid, 1'b0);
`else
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("noscan_res_valid", res_valid, 1'b0);
            check("noscan_q", q, qv);
            step("noscan");
        end
        if (with_load || exp_found || exp_idx != 0 || exp_lat != 0) begin
            check("noscan_ready", cmd_ready, 1'b1);
        end
`endif
    endtask

    typedef struct {
        logic [1:0]    op;
        int            idx;
        logic          val;
        logic [W-1:0]  data;
        logic [W-1:0]  exp_q;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{2'b00, 3, 1'b1, 8'h00, 8'h08};
        tbl[1] = '{2'b01, 0, 1'b0, 8'h00, 8'h09};
        tbl[2] = '{2'b00, 3, 1'b0, 8'h00, 8'h01};
        tbl[3] = '{2'b10, 0, 1'b0, 8'hA5, 8'hA5};
        tbl[4] = '{2'b01, 7, 1'b0, 8'h00, 8'h25};
        tbl[5] = '{2'b00, 0, 1'b0, 8'h00, 8'h24};
        tbl[6] = '{2'b00, 6, 1'b1, 8'h00, 8'h64};

        rst_n = 1'b0;
        drive(1'b0, 2'b00, 0, 1'b0, '0);
        model_reset();
        #12;
        check("reset_q", q, 8'h00);
        check("reset_ready", cmd_ready, 1'b1);
        check("reset_res_valid", res_valid, 1'b0);
        compare_all("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        step("idle");

        // Bit ops on consecutive accept edges
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, tbl[i].op, tbl[i].idx, tbl[i].val, tbl[i].data);
            step("bitop");
            check("bitop_table_q", q, tbl[i].exp_q);
        end
        cmd_valid = 1'b0;
        step("bitop_idle");

        scan_seq(8'h20, 1, 1'b1, 1'b0, 1'b1, 5, 5);
        scan_seq(8'h01, 6, 1'b1, 1'b0, 1'b1, 0, 3);
        scan_seq(8'hFE, 0, 1'b0, 1'b0, 1'b1, 0, 1);
        scan_seq(8'hFF, 2, 1'b0, 1'b1, 1'b0, 2, 8);

        // Reset asserted mid-cycle during a long scan
        drive(1'b1, 2'b10, 0, 1'b0, 8'h80);
        step("rst_preload");
        drive(1'b1, 2'b11, 0, 1'b1, '0);
        step("rst_accept");
        cmd_valid = 1'b0;
        step("rst_scan1");
        step("rst_scan2");
        step("rst_scan3");
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_q", q, 8'h00);
        check("async_rst_ready", cmd_ready, 1'b1);
        check("async_rst_res_valid", res_valid, 1'b0);
        step("rst_held");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step("post_rst");
            check("post_rst_no_pulse", res_valid, 1'b0);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(3) != 0), 2'($urandom_range(3)), int'($urandom_range(W - 1)),
                  1'($urandom_range(1)), W'($urandom));
            step("rand");
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < W + 2; i++) step("drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
